two_port_bus_arbiter: RTL and testbench
=======================================

// Module: two_port_bus_arbiter
// PURPOSE
//  Shares one 8-bit output bus between two requesters (A, B) by driving the select of an
//  eight_bit_2_1_mux instance. Round-robin arbitration, burst-hold grants, one registered output stage.
//  Sits between two byte producers and a single downstream consumer with valid/ready flow control.
// PARAMETERS
//  MAX_BURST   4   max beats per grant before forced release; legal range 1..255
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  reset; one clock; reset is asynchronous and active-low
//  req_a      in   1  A has a beat on data_a; hold until acked
//  data_a     in   8  A beat data
//  last_a     in   1  A beat is last of burst (qualified by req_a)
//  ack_a      out  1  A beat accepted this cycle (combinational)
//  req_b      in   1  as req_a, requester B
//  data_b     in   8  as data_a, requester B
//  last_b     in   1  as last_a, requester B
//  ack_b      out  1  as ack_a, requester B
//  out_data   out  8  registered bus data
//  out_src    out  1  registered source of out_data: 0=A, 1=B
//  out_valid  out  1  out_data valid
//  out_ready  in   1  consumer accepts when out_valid & out_ready
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, prio=A, beat_cnt=0, out_data=0, out_src=0, out_valid=0; ack_a=ack_b=busy=0.
//  States: IDLE, GNT_A, GNT_B (2-bit encoding). Mux select s = (state==GNT_B).
//  load_en = !out_valid | out_ready.
//  IDLE: req_a&req_b -> GNT_<prio>; else req_a -> GNT_A; else req_b -> GNT_B; else stay. No ack in IDLE.
//  GNT_x: ack_x = req_x & load_en; other ack = 0. On ack_x: out_data<=mux out, out_src<=x, out_valid<=1,
//   beat_cnt++.
//  Release GNT_x -> IDLE next cycle when any of: ack_x & last_x; ack_x & beat_cnt+1==MAX_BURST;
//   !req_x (requester withdrew). On release: prio <= other requester, beat_cnt <= 0.
//  Release always passes through IDLE: one dead cycle between grants (2 cycles min per grant switch).
//  Output stage: out_valid & out_ready & !ack -> out_valid<=0; simultaneous consume+load keeps
//   out_valid=1 with new data (full throughput, 1 beat/cycle within a grant).
//  Backpressure: out_valid & !out_ready -> load_en=0, no ack, out_data/out_src held stable, grant held,
//   beat_cnt unchanged.
//  Latency: req in IDLE at cycle n -> grant at n+1 -> ack at n+1 (if load_en) -> out_valid at n+2.
//  beat_cnt 8 bits; never exceeds MAX_BURST-1 while in GNT_x; MAX_BURST=1 gives single-beat grants.
//  Only one ack can be high in any cycle; no beat duplicated or dropped.
//  Reset mid-operation: everything returns to reset values immediately; a pending out beat is lost.
// STRUCTURE
//  Shared include arb_defs.vh: state localparams ST_IDLE=2'd0, ST_GNT_A=2'd1, ST_GNT_B=2'd2;
//   SRC_A=1'b0, SRC_B=1'b1.
//  Sub-module: one eight_bit_2_1_mux (a=data_a, b=data_b, s=grant_b) feeding the out register.
//  FSM, beat counter and output register live in this module.
// TESTING
//  1 Only A: req_a with 3 beats 0x11,0x22,0x33(last), out_ready=1 -> acks at n+1..n+3,
//    out_src=0, data in order, back to IDLE.
//  2 Both request at reset release, each 2 beats with last -> A served first (prio=A), one IDLE cycle,
//    then B; out_src 0,0,1,1.
//  3 Both request continuously, no last, MAX_BURST=4 -> alternating bursts of exactly 4 beats A,B,A,B.
//  4 Backpressure: out_ready=0 for 3 cycles mid-burst -> out_data/out_src stable, no ack,
//    beat_cnt frozen; resumes with no loss.
//  5 Withdraw: B granted, req_b dropped after 1 beat -> IDLE next cycle, prio=A, pending req_a
//    granted on following cycle.
//  6 rst_n asserted while GNT_B with out_valid=1 -> all outputs 0 same cycle; after release,
//    first grant goes to A when both request.

Source files
------------

// File: rtl/two_port_bus_arbiter_pkg.sv
// Shared types and constants for the two-port bus arbiter: FSM state encoding
// and the source codes reported on out_src.
package two_port_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } arb_state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int DATA_W = 8;

    // Round-robin priority always moves to the requester that was not just served.
    function automatic logic other_src(input logic src);
        return (src == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/eight_bit_2_1_mux.sv
// Byte-wide 2:1 multiplexer; s=0 selects a, s=1 selects b.
module eight_bit_2_1_mux (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       s,
    output logic [7:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/two_port_bus_arbiter.sv
// Round-robin arbiter sharing one registered byte bus between requesters A and B,
// with burst-hold grants, a forced release after MAX_BURST beats and valid/ready output.
module two_port_bus_arbiter
    import two_port_bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              last_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              last_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);

    arb_state_e        state;
    arb_state_e        next_state;
    logic              prio;
    logic [7:0]        beat_cnt;
    logic [DATA_W-1:0] mux_y;
    logic              grant_a;
    logic              grant_b;
    logic              ack_any;
    logic              cur_req;
    logic              cur_last;
    logic              burst_done;
    logic              load_en;
    logic              release_grant;

    eight_bit_2_1_mux u_mux (
        .a (data_a),
        .b (data_b),
        .s (grant_b),
        .y (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req_a && req_b) begin
                    next_state = (prio == SRC_B) ? ST_GNT_B : ST_GNT_A;
                end else if (req_a) begin
                    next_state = ST_GNT_A;
                end else if (req_b) begin
                    next_state = ST_GNT_B;
                end
            end
            ST_GNT_A, ST_GNT_B: begin
                if (release_grant) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // A grant ends on the last beat, on reaching the burst limit, or when the owner withdraws.
    always_comb begin
        grant_a       = (state == ST_GNT_A);
        grant_b       = (state == ST_GNT_B);
        busy          = (state != ST_IDLE);
        load_en       = !out_valid || out_ready;
        ack_a         = grant_a && req_a && load_en;
        ack_b         = grant_b && req_b && load_en;
        ack_any       = ack_a || ack_b;
        cur_req       = grant_b ? req_b : req_a;
        cur_last      = grant_b ? last_b : last_a;
        burst_done    = (({1'b0, beat_cnt} + 9'd1) == BURST_LIMIT);
        release_grant = busy && ((ack_any && (cur_last || burst_done)) || !cur_req);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio      <= SRC_A;
            beat_cnt  <= 8'd0;
            out_data  <= '0;
            out_src   <= SRC_A;
            out_valid <= 1'b0;
        end else begin
            if (release_grant) begin
                prio     <= other_src(grant_b ? SRC_B : SRC_A);
                beat_cnt <= 8'd0;
            end else if (ack_any) begin
                beat_cnt <= beat_cnt + 8'd1;
            end

            if (ack_any) begin
                out_data  <= mux_y;
                out_src   <= grant_b ? SRC_B : SRC_A;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_two_port_bus_arbiter.sv
// Scoreboard bench for two_port_bus_arbiter: a transaction-level round-robin model
// predicts the output beat order, and a monitor checks every consumed beat.
module tb_two_port_bus_arbiter;

    localparam int MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, last_a, ack_a;
    logic       req_b, last_b, ack_b;
    logic [7:0] data_a, data_b, out_data;
    logic       out_src, out_valid, out_ready, busy;

    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [8:0] sb[$];
    logic       model_prio;
    int         ready_pct;
    int         checks;
    int         failures;
    logic       take_a, take_b;

    logic       hold_prev;
    logic [7:0] prev_data;
    logic       prev_src;

    always #5 clk = ~clk;

    two_port_bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .data_a    (data_a),
        .last_a    (last_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .last_b    (last_b),
        .ack_b     (ack_b),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Grant-level model: pick by priority when both have beats, serve until last,
    // burst limit or the queue runs dry, then hand priority to the other side.
    task automatic push_model(input logic [8:0] a[$], input logic [8:0] b[$]);
        int         ia, ib, beats;
        logic       pick_b, done;
        logic [8:0] beat;
        ia = 0;
        ib = 0;
        while (ia < a.size() || ib < b.size()) begin
            if (ia < a.size() && ib < b.size()) pick_b = model_prio;
            else pick_b = (ib < b.size());
            beats = 0;
            done  = 1'b0;
            while (!done) begin
                if (pick_b) begin
                    beat = b[ib];
                    ib++;
                    done = (ib >= b.size());
                end else begin
                    beat = a[ia];
                    ia++;
                    done = (ia >= a.size());
                end
                beats++;
                sb.push_back({pick_b, beat[7:0]});
                if (beat[8] || beats == MAX_BURST) done = 1'b1;
            end
            model_prio = !pick_b;
        end
    endtask

    task automatic apply_stimulus();
        if (qa.size() > 0) begin
            req_a = 1'b1;
            {last_a, data_a} = qa[0];
        end else begin
            req_a = 1'b0; last_a = 1'b0; data_a = 8'h00;
        end
        if (qb.size() > 0) begin
            req_b = 1'b1;
            {last_b, data_b} = qb[0];
        end else begin
            req_b = 1'b0; last_b = 1'b0; data_b = 8'h00;
        end
        out_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic step_cycle();
        @(negedge clk);
        take_a = req_a && ack_a;
        take_b = req_b && ack_b;
        @(posedge clk);
        #1;
        if (take_a && qa.size() > 0) void'(qa.pop_front());
        if (take_b && qb.size() > 0) void'(qb.pop_front());
        apply_stimulus();
    endtask

    task automatic wait_idle(input int budget);
        int quiet;
        quiet = 0;
        for (int i = 0; i < budget && quiet < 2; i++) begin
            step_cycle();
            if (sb.size() == 0 && qa.size() == 0 && qb.size() == 0 && !busy) quiet++;
            else quiet = 0;
        end
        check_output("drain_timeout", quiet >= 2, 1);
        if (quiet < 2) begin
            qa.delete();
            qb.delete();
            sb.delete();
        end
    endtask

    task automatic load_random(input int max_len, input int last_pct);
        int len;
        len = $urandom_range(0, max_len);
        for (int i = 0; i < len; i++)
            qa.push_back({($urandom_range(0, 99) < last_pct), 8'($urandom)});
        len = $urandom_range(0, max_len);
        for (int i = 0; i < len; i++)
            qb.push_back({($urandom_range(0, 99) < last_pct), 8'($urandom)});
    endtask

    // Monitor: compare every consumed beat against the scoreboard and check that
    // backpressure freezes the bus and suppresses acks.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (ack_a || ack_b) check_output("single_ack", {31'd0, ack_a && ack_b}, 0);
            if (hold_prev) begin
                check_output("hold_valid", {31'd0, out_valid}, 1);
                check_output("hold_data", {24'd0, out_data}, {24'd0, prev_data});
                check_output("hold_src", {31'd0, out_src}, {31'd0, prev_src});
            end
            if (out_valid && !out_ready)
                check_output("stall_no_ack", {31'd0, ack_a || ack_b}, 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_beat", {23'd0, out_src, out_data}, 32'h1ff);
                end else begin
                    logic [8:0] exp;
                    exp = sb.pop_front();
                    check_output("beat_data", {24'd0, out_data}, {24'd0, exp[7:0]});
                    check_output("beat_src", {31'd0, out_src}, {31'd0, exp[8]});
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_src  = out_src;
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        hold_prev = 1'b0;
        model_prio = 1'b0;
        ready_pct = 100;
        rst_n = 1'b0;
        req_a = 0; data_a = 0; last_a = 0;
        req_b = 0; data_b = 0; last_b = 0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", {31'd0, out_valid}, 0);
        check_output("rst_busy", {31'd0, busy}, 0);
        check_output("rst_data", {24'd0, out_data}, 0);
        rst_n = 1'b1;

        // Single requester, three beats: latency and return to idle.
        qa.push_back({1'b0, 8'h11});
        qa.push_back({1'b0, 8'h22});
        qa.push_back({1'b1, 8'h33});
        push_model(qa, qb);
        apply_stimulus();
        check_output("lat_idle_ack", {31'd0, ack_a}, 0);
        check_output("lat_idle_busy", {31'd0, busy}, 0);
        step_cycle();
        check_output("lat_gnt_ack", {31'd0, ack_a}, 1);
        check_output("lat_gnt_busy", {31'd0, busy}, 1);
        check_output("lat_gnt_valid", {31'd0, out_valid}, 0);
        step_cycle();
        check_output("lat_out_valid", {31'd0, out_valid}, 1);
        step_cycle();
        step_cycle();
        check_output("lat_release", {31'd0, busy}, 0);
        wait_idle(100);

        // Continuous requests without last: alternating bursts of MAX_BURST.
        for (int i = 0; i < 12; i++) begin
            qa.push_back({1'b0, 8'(8'hA0 + i)});
            qb.push_back({1'b0, 8'(8'hB0 + i)});
        end
        push_model(qa, qb);
        apply_stimulus();
        wait_idle(500);

        // Random bursts and random backpressure.
        for (int p = 0; p < 10; p++) begin
            ready_pct = $urandom_range(30, 100);
            load_random(12, 25);
            push_model(qa, qb);
            apply_stimulus();
            wait_idle(2000);
        end

        // Reset while B holds the bus with a beat pending.
        ready_pct = 50;
        for (int i = 0; i < 20; i++) qb.push_back({1'b0, 8'(8'hC0 + i)});
        push_model(qa, qb);
        apply_stimulus();
        for (int i = 0; i < 200 && !(busy && out_valid && out_src); i++) step_cycle();
        check_output("pre_reset_state", {31'd0, busy && out_valid && out_src}, 1);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_valid", {31'd0, out_valid}, 0);
        check_output("mid_rst_src", {31'd0, out_src}, 0);
        check_output("mid_rst_data", {24'd0, out_data}, 0);
        check_output("mid_rst_busy", {31'd0, busy}, 0);
        check_output("mid_rst_ack", {30'd0, ack_a, ack_b}, 0);
        qa.delete();
        qb.delete();
        sb.delete();
        model_prio = 1'b0;
        ready_pct = 100;
        apply_stimulus();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both request right after reset: A first, then B.
        qa.push_back({1'b0, 8'h01});
        qa.push_back({1'b1, 8'h02});
        qb.push_back({1'b0, 8'h03});
        qb.push_back({1'b1, 8'h04});
        push_model(qa, qb);
        apply_stimulus();
        step_cycle();
        check_output("post_rst_grant_a", {30'd0, ack_a, ack_b}, 32'd2);
        wait_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
